// File: rtl/ctrl_dec_if.sv
// ctrl_dec_if: bundles the instruction handshake and the registered decode
// outputs of ctrl_dec.
//   in_valid/in_ready/instr : instruction handshake (producer -> decoder)
//   flush                   : drop current input, clear hazard and halt state
//   ctrl_out/rd_out/rs1_out/rs2_out : registered control word and fields
//   halted                  : registered HALT indication
//   bubble_cnt              : stall/halt bubble counter, present only when
//                             CTRL_DEC_PERF_CNT_EN is defined
// Modports: master = instruction producer / output consumer, slave = decoder.
interface ctrl_dec_if #(
  parameter int WIDTH = 8,
  parameter int IW    = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IW-1:0]    instr;
  logic             flush;
  logic [WIDTH-1:0] ctrl_out;
  logic [3:0]       rd_out;
  logic [3:0]       rs1_out;
  logic [3:0]       rs2_out;
  logic             halted;
`ifdef CTRL_DEC_PERF_CNT_EN
  logic [15:0]      bubble_cnt;

  modport master (
    output in_valid, instr, flush,
    input  in_ready, ctrl_out, rd_out, rs1_out, rs2_out, halted, bubble_cnt
  );
  modport slave (
    input  in_valid, instr, flush,
    output in_ready, ctrl_out, rd_out, rs1_out, rs2_out, halted, bubble_cnt
  );
`else
  modport master (
    output in_valid, instr, flush,
    input  in_ready, ctrl_out, rd_out, rs1_out, rs2_out, halted
  );
  modport slave (
    input  in_valid, instr, flush,
    output in_ready, ctrl_out, rd_out, rs1_out, rs2_out, halted
  );
`endif
endinterface

// File: rtl/ctrl_dec.sv
// ctrl_dec: decode stage feeding the 4-stage control-word delay line.
// Accepts 16-bit instructions over valid/ready and registers one WIDTH-bit
// control word per clock. Emits an all-zero bubble whenever nothing valid is
// issued (the delay line has no enable), inserts one bubble on a load-use
// hazard and halts on illegal opcodes until flushed.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ctrl_dec_if.slave (handshake, flush, registered outputs, halted)
// Optional feature: define CTRL_DEC_PERF_CNT_EN to add bus.bubble_cnt, a
// saturating 16-bit count of bubbles caused by hazard stalls or HALT.
module ctrl_dec #(
  parameter int WIDTH = 8,
  parameter int IW    = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  ctrl_dec_if.slave bus
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] ctrl_q, ctrl_d;
  logic [3:0]       rd_q, rd_d;
  logic [3:0]       rs1_q, rs1_d;
  logic [3:0]       rs2_q, rs2_d;
  logic             last_ld_q, last_ld_d;
  logic [3:0]       last_rd_q, last_rd_d;

  // Instruction fields
  logic [IW-1:0] instr_w;
  logic [3:0]    op, f_rd, f_rs1, f_rs2;
  assign instr_w = bus.instr;
  assign op      = instr_w[15:12];
  assign f_rd    = instr_w[11:8];
  assign f_rs1   = instr_w[7:4];
  assign f_rs2   = instr_w[3:0];

  // Opcode decode: control byte, legality and which fields are read
  logic [7:0] dec_word;
  logic       legal;
  logic       use_rs1, use_rs2, use_rd;

  always_comb begin
    dec_word = 8'h00;
    legal    = 1'b1;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    case (op)
      4'h0: ;                                                             // NOP
      4'h1: begin dec_word = 8'h01; use_rs1 = 1'b1; use_rs2 = 1'b1; end // ADD
      4'h2: begin dec_word = 8'h21; use_rs1 = 1'b1; use_rs2 = 1'b1; end // SUB
      4'h3: begin dec_word = 8'h41; use_rs1 = 1'b1; use_rs2 = 1'b1; end // AND
      4'h4: begin dec_word = 8'h61; use_rs1 = 1'b1; use_rs2 = 1'b1; end // OR
      4'h5: begin dec_word = 8'h11; use_rs1 = 1'b1; end                 // ADDI
      4'h6: begin dec_word = 8'h1B; use_rs1 = 1'b1; end                 // LD
      4'h7: begin dec_word = 8'h14; use_rs1 = 1'b1; use_rd = 1'b1; end  // ST reads rd as data
      default: legal = 1'b0;
    endcase
    // Writes to r0 are discarded
    if (f_rd == 4'd0) dec_word[0] = 1'b0;
  end

  // Load-use hazard against the previously issued load; r0 never hazards
  logic hazard;
  assign hazard = last_ld_q && (last_rd_q != 4'd0) &&
                  ((use_rs1 && (f_rs1 == last_rd_q)) ||
                   (use_rs2 && (f_rs2 == last_rd_q)) ||
                   (use_rd  && (f_rd  == last_rd_q)));

  // A flush accepts and drops the input even when a hazard is present
  assign bus.in_ready = (state_q == ST_RUN) && (bus.flush || !hazard);

  always_comb begin
    state_d   = state_q;
    ctrl_d    = '0;
    rd_d      = 4'd0;
    rs1_d     = 4'd0;
    rs2_d     = 4'd0;
    last_ld_d = 1'b0;
    last_rd_d = last_rd_q;
    if (state_q == ST_HALT) begin
      if (bus.flush) state_d = ST_RUN;
    end else if (bus.flush) begin
      // bubble, input dropped
    end else if (bus.in_valid && hazard) begin
      // stall bubble; instruction held by producer
    end else if (bus.in_valid) begin
      if (legal) begin
        ctrl_d[7:0] = dec_word;
        rd_d        = f_rd;
        rs1_d       = f_rs1;
        rs2_d       = f_rs2;
        last_ld_d   = (op == 4'h6);
        last_rd_d   = f_rd;
      end else begin
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      ctrl_q    <= '0;
      rd_q      <= 4'd0;
      rs1_q     <= 4'd0;
      rs2_q     <= 4'd0;
      last_ld_q <= 1'b0;
      last_rd_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      last_ld_q <= last_ld_d;
      last_rd_q <= last_rd_d;
    end
  end

  assign bus.ctrl_out = ctrl_q;
  assign bus.rd_out   = rd_q;
  assign bus.rs1_out  = rs1_q;
  assign bus.rs2_out  = rs2_q;
  assign bus.halted   = (state_q == ST_HALT);

`ifdef CTRL_DEC_PERF_CNT_EN
  // Counts bubbles produced while halted or by a load-use stall; flush
  // does not clear it.
  logic        stall_bubble;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  assign stall_bubble = (state_q == ST_HALT) ||
                        (!bus.flush && bus.in_valid && hazard);

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (stall_bubble && (bubble_cnt_q != 16'hFFFF))
      bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_cnt_q <= 16'd0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_dec.sv
// tb_ctrl_dec: directed plus randomized stimulus for ctrl_dec, checked
// against a table-driven reference model of the decode rules.
module tb_ctrl_dec;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ctrl_dec_if #(.WIDTH(8), .IW(16)) bus ();

  ctrl_dec #(.WIDTH(8), .IW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  ctrl_tab [8];
  logic        m_halt;
  logic        m_last_ld;
  logic [3:0]  m_last_rd;
  logic [7:0]  m_ctrl;
  logic [3:0]  m_rd, m_rs1, m_rs2;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_halt = 0; m_last_ld = 0; m_last_rd = 0;
    m_ctrl = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_cnt = 0;
  endtask

  function automatic bit reads_reg(input logic [15:0] ins, input logic [3:0] r);
    int o;
    o = int'(ins[15:12]);
    if (o >= 1 && o <= 7 && ins[7:4] == r) return 1;
    if (o >= 1 && o <= 4 && ins[3:0] == r) return 1;
    if (o == 7 && ins[11:8] == r) return 1;
    return 0;
  endfunction

  // One clock of stimulus: drive, check in_ready, clock, check outputs
  task automatic step(input logic v, input logic [15:0] ins, input logic fl);
    bit hz;
    bit exp_ready;
    int o;
    bus.in_valid = v;
    bus.instr    = ins;
    bus.flush    = fl;
    #1;
    o  = int'(ins[15:12]);
    hz = m_last_ld && (m_last_rd != 0) && reads_reg(ins, m_last_rd);
    exp_ready = !m_halt && (fl || !hz);
    check_eq("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    // model update
    m_ctrl = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    if (m_halt) begin
      if (m_cnt < 65535) m_cnt++;
      if (fl) m_halt = 0;
      m_last_ld = 0;
    end else if (fl) begin
      m_last_ld = 0;
    end else if (v && hz) begin
      if (m_cnt < 65535) m_cnt++;
      m_last_ld = 0;
    end else if (v) begin
      if (o >= 8) begin
        m_halt = 1;
        m_last_ld = 0;
      end else begin
        m_ctrl = ctrl_tab[o];
        if (ins[11:8] == 0) m_ctrl[0] = 1'b0;
        m_rd = ins[11:8]; m_rs1 = ins[7:4]; m_rs2 = ins[3:0];
        m_last_ld = (o == 6);
        m_last_rd = ins[11:8];
      end
    end else begin
      m_last_ld = 0;
    end
    @(posedge clk);
    #1;
    check_eq("ctrl_out", 32'(bus.ctrl_out), 32'(m_ctrl));
    check_eq("rd_out",   32'(bus.rd_out),   32'(m_rd));
    check_eq("rs1_out",  32'(bus.rs1_out),  32'(m_rs1));
    check_eq("rs2_out",  32'(bus.rs2_out),  32'(m_rs2));
    check_eq("halted",   32'(bus.halted),   32'(m_halt));
`ifdef CTRL_DEC_PERF_CNT_EN
    check_eq("bubble_cnt", 32'(bus.bubble_cnt), 32'(m_cnt));
`endif
    $display("cyc v=%0d instr=%04h flush=%0d -> ctrl=%02h rd=%0d rs1=%0d rs2=%0d halted=%0d",
             v, ins, fl, bus.ctrl_out, bus.rd_out, bus.rs1_out, bus.rs2_out, bus.halted);
  endtask

  initial begin
    logic [15:0] ri;
    logic        rv, rf;
    total = 0;
    bad   = 0;
    ctrl_tab = '{8'h00, 8'h01, 8'h21, 8'h41, 8'h61, 8'h11, 8'h1B, 8'h14};
    model_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr    = 16'h0000;
    bus.flush    = 1'b0;
    #7;
    check_eq("rst_ctrl",   32'(bus.ctrl_out), 32'h0);
    check_eq("rst_halted", 32'(bus.halted),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ADD, 1-cycle latency
    step(1, 16'h1123, 0);
    check_eq("add_ctrl", 32'(bus.ctrl_out), 32'h01);
    check_eq("add_rd",   32'(bus.rd_out),   32'h1);
    check_eq("add_rs1",  32'(bus.rs1_out),  32'h2);
    check_eq("add_rs2",  32'(bus.rs2_out),  32'h3);

    // Reset asserted mid-issue clears everything asynchronously
    bus.in_valid = 1'b1;
    bus.instr    = 16'h1123;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ctrl", 32'(bus.ctrl_out), 32'h0);
    check_eq("arst_rd",   32'(bus.rd_out),   32'h0);
    check_eq("arst_rs1",  32'(bus.rs1_out),  32'h0);
    check_eq("arst_rs2",  32'(bus.rs2_out),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(0, 16'h0000, 0);
    check_eq("post_rst_ctrl", 32'(bus.ctrl_out), 32'h0);

    // LD then dependent ADD: one bubble
    step(1, 16'h6204, 0);
    check_eq("ld_ctrl", 32'(bus.ctrl_out), 32'h1B);
    step(1, 16'h1223, 0);
    check_eq("ld_use_bubble", 32'(bus.ctrl_out), 32'h00);
    step(1, 16'h1223, 0);
    check_eq("ld_use_add", 32'(bus.ctrl_out), 32'h01);
`ifdef CTRL_DEC_PERF_CNT_EN
    check_eq("cnt_one", 32'(bus.bubble_cnt), 32'h1);
`endif

    // LD to r0 never stalls
    step(1, 16'h6004, 0);
    check_eq("ld_r0_ctrl", 32'(bus.ctrl_out), 32'h1A);
    step(1, 16'h1003, 0);
    check_eq("add_r0_ctrl", 32'(bus.ctrl_out), 32'h00);

    // Illegal opcode halts until flush
    step(1, 16'h9000, 0);
    check_eq("ill_halted", 32'(bus.halted), 32'h1);
    for (int i = 0; i < 5; i++) step(1, 16'h9000, 0);
    step(0, 16'h0000, 1);
    check_eq("flush_run", 32'(bus.halted), 32'h0);
    step(1, 16'h1123, 0);
    check_eq("after_flush_add", 32'(bus.ctrl_out), 32'h01);

    // ST reading a just-loaded rd stalls one cycle
    step(1, 16'h6304, 0);
    step(1, 16'h7315, 0);
    check_eq("st_stall", 32'(bus.ctrl_out), 32'h00);
    step(1, 16'h7315, 0);
    check_eq("st_ctrl", 32'(bus.ctrl_out), 32'h14);

    // Flush during a hazard wins
    step(1, 16'h6204, 0);
    step(1, 16'h1223, 1);
    check_eq("flush_hz", 32'(bus.ctrl_out), 32'h00);

    // Randomized traffic with small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      ri[15:12] = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(8, 15))
                                               : 4'($urandom_range(0, 7));
      ri[11:8]  = 4'($urandom_range(0, 3));
      ri[7:4]   = 4'($urandom_range(0, 3));
      ri[3:0]   = 4'($urandom_range(0, 3));
      rv = ($urandom_range(0, 3) != 0);
      rf = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
      step(rv, ri, rf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
